divider_hilo: RTL and testbench
===============================

Name: divider_hilo

Overview:
- Multi-cycle 32-bit unsigned divider with the architectural HI/LO register pair.
- Sits downstream of the ALU control stage and consumes its 6-bit function code (SignaltoDIV).
- Performs one restoring-division step per clock while DIVU is presented.
- Commits to HI/LO on the open-HiLo code 6'b111111, and serves MFHI/MFLO reads.

Parameters:
- WIDTH, 32: operand, quotient and remainder width.
- STEPS, 32: iteration count; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- dataA  input  WIDTH  dividend (rs).
- dataB  input  WIDTH  divisor (rt).
- Signal  input  6  function code from the ALU control stage.
- dataOut  output  WIDTH  HI when Signal==MFHI, LO when Signal==MFLO, else 0; combinational from registered HI/LO.
- busy  output  1  high while in RUN or DONE.

Behaviour:
- Function codes: DIVU=6'b011011, MFHI=6'b010000, MFLO=6'b010010, OPEN_HILO=6'b111111.
- Internal state:
  - rem, WIDTH+1 bits (partial remainder).
  - quo, WIDTH bits.
  - divisor latch, WIDTH bits.
  - cnt, 6 bits.
  - FSM {IDLE, RUN, DONE}.
- Reset (async, active-high), all taking effect immediately:
  - FSM=IDLE; HI=0, LO=0; rem=0, quo=0, cnt=0.
  - busy=0; dataOut=0 unless Signal selects MFHI/MFLO, in which case it shows 0.
- IDLE: on the posedge with Signal==DIVU:
  - Load quo=dataA, divisor latch=dataB, rem=0, cnt=0.
  - Go to RUN.
  - Other codes: no action.
- RUN: each posedge with Signal==DIVU performs one step:
  - t = {rem[WIDTH-1:0], quo[WIDTH-1]}; quo = quo<<1.
  - If t >= {1'b0,divisor}: rem = t - divisor, quo[0]=1. Else rem = t, quo[0]=0.
  - cnt++.
  - When cnt reaches STEPS (i.e. the 33rd DIVU edge counting the load), go to DONE.
- RUN abort: a posedge in RUN with Signal != DIVU aborts to IDLE. HI/LO are unchanged and cnt=0.
- DONE:
  - Posedge with Signal==OPEN_HILO: HI=rem[WIDTH-1:0], LO=quo, go to IDLE.
  - Signal==DIVU: hold (no further steps).
  - Any other code: drop the result and go to IDLE.
- Operand sampling: operands are sampled only at load; changes to dataA/dataB during RUN are ignored.
- Divide by zero (feature off):
  - Natural restoring result: LO=all ones, HI=dividend.
- MFHI/MFLO read:
  - Reads HI/LO as they stand; no forwarding of an in-flight result.
  - A commit on edge N is visible to MFHI/MFLO from edge N onward.
- Latency: 33 DIVU edges plus 1 OPEN_HILO edge gives the commit.
- Back-to-back DIVU with no intervening code: it is one operation; a new one starts only from IDLE.
- Reset mid-RUN/DONE: immediate return to IDLE with HI/LO cleared.

Optional Feature:
- Macro: DIVU_ZERO_TRAP_EN.
- Defined:
  - Extra output divZero (1 bit, reset 0).
  - At load, if dataB==0, set divZero and go directly to DONE without stepping.
  - On OPEN_HILO the HI/LO write is suppressed.
  - divZero clears on the next load or on reset.
- Undefined: no port, no special case; the zero-divisor result follows the restoring algorithm as above.

Decomposition:
- Shared package: function-code constants (DIVU, MFHI, MFLO, OPEN_HILO, plus AND/OR/ADD/SUB/SLT/SRL for consistency) and the FSM state enumeration.
- The ALU control stage uses the same constants.
- One natural sub-module: div_step, a combinational single restoring step (rem, quo, divisor in; next rem, quo out), instantiated once.

Test Plan:
- DIVU dataA=100, dataB=7 for 33 edges, then OPEN_HILO -> HI=2, LO=14. MFHI gives dataOut=2; MFLO gives 14.
- dataA=0xFFFFFFFF, dataB=1 full sequence -> LO=0xFFFFFFFF, HI=0. busy high for edges 1-33 and low after commit.
- dataB=0 full sequence:
  - Feature off -> LO=0xFFFFFFFF, HI=dataA.
  - Feature on -> divZero=1 after load, HI/LO keep prior values (e.g. 2/14).
- DIVU 10 edges, then ADD, then OPEN_HILO -> FSM IDLE after the ADD edge, HI/LO unchanged.
- Assert reset at DIVU edge 20 of 40/6 -> HI=LO=0 and busy=0 immediately. A fresh 40/6 run then gives HI=4, LO=6.
- Change dataA/dataB mid-RUN of 1000/33 -> result is still HI=10, LO=30.

Source files
------------

// File: rtl/divider_hilo_pkg.sv
// Shared definitions for the divider/HI-LO block and the ALU control stage:
// function-code constants and the divider FSM state encoding.
package divider_hilo_pkg;

    localparam int FN_W = 6;

    localparam logic [FN_W-1:0] FN_DIVU      = 6'b011011;
    localparam logic [FN_W-1:0] FN_MFHI      = 6'b010000;
    localparam logic [FN_W-1:0] FN_MFLO      = 6'b010010;
    localparam logic [FN_W-1:0] FN_OPEN_HILO = 6'b111111;
    localparam logic [FN_W-1:0] FN_ADD       = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB       = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND       = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR        = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT       = 6'b101010;
    localparam logic [FN_W-1:0] FN_SRL       = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_hilo_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor when it fits, record the quotient bit.
module divider_hilo_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] trial_s;
    logic [WIDTH:0] divisor_ext_s;

    assign trial_s       = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    assign divisor_ext_s = {1'b0, divisor_i};

    // Restore (keep the shifted remainder) when the divisor does not fit.
    always_comb begin
        if (trial_s >= divisor_ext_s) begin
            rem_o = trial_s - divisor_ext_s;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = trial_s;
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_hilo.sv
// Multi-cycle unsigned divider with the architectural HI/LO pair.
// Optional macro DIVU_ZERO_TRAP_EN adds divZero and suppresses the commit on a zero divisor.
module divider_hilo
    import divider_hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy
`ifdef DIVU_ZERO_TRAP_EN
    ,
    output logic             divZero
`endif
);

    localparam logic [5:0] STEPS_C = 6'(STEPS);

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             zero_q, zero_d;

    logic [WIDTH:0]   step_rem_s;
    logic [WIDTH-1:0] step_quo_s;

    divider_hilo_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem_s),
        .quo_o     (step_quo_s)
    );

    // Next-state logic for the FSM, datapath and HI/LO.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        zero_d    = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (Signal == FN_DIVU) begin
                    quo_d     = dataA;
                    divisor_d = dataB;
                    rem_d     = {(WIDTH+1){1'b0}};
                    cnt_d     = 6'd0;
                    state_d   = ST_RUN;
`ifdef DIVU_ZERO_TRAP_EN
                    zero_d = (dataB == {WIDTH{1'b0}});
                    if (dataB == {WIDTH{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (Signal == FN_DIVU) begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = cnt_q + 6'd1;
                    if ((cnt_q + 6'd1) == STEPS_C) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d   = 6'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (Signal == FN_OPEN_HILO) begin
                    if (!zero_q) begin
                        hi_d = rem_q[WIDTH-1:0];
                        lo_d = quo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                    state_d = ST_IDLE;
                end else if (Signal == FN_DIVU) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // All state registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rem_q     <= {(WIDTH+1){1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            divisor_q <= {WIDTH{1'b0}};
            cnt_q     <= 6'd0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            zero_q    <= zero_d;
        end
    end

    // Read port shows the committed HI/LO only; in-flight results are never forwarded.
    always_comb begin
        case (Signal)
            FN_MFHI: dataOut = hi_q;
            FN_MFLO: dataOut = lo_q;
            default: dataOut = {WIDTH{1'b0}};
        endcase
    end

    assign busy = busy_q;
`ifdef DIVU_ZERO_TRAP_EN
    assign divZero = zero_q;
`endif

endmodule

// File: tb/tb_divider_hilo.sv
// Scoreboard bench for divider_hilo: expected HI/LO are queued at commit time
// and popped when read back through MFHI/MFLO.
module tb_divider_hilo;
    import divider_hilo_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] dataOut;
    logic        busy;
`ifdef DIVU_ZERO_TRAP_EN
    logic        divZero;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    divider_hilo dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut),
        .busy    (busy)
`ifdef DIVU_ZERO_TRAP_EN
        ,
        .divZero (divZero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [5:0] sig);
        Signal = sig;
        @(posedge clk);
        #1;
    endtask

    // Reference model of the architectural result.
    task automatic model_div(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) begin
`ifdef DIVU_ZERO_TRAP_EN
            hi_m = hi_m;
            lo_m = lo_m;
`else
            hi_m = a;
            lo_m = 32'hFFFF_FFFF;
`endif
        end else begin
            hi_m = a % b;
            lo_m = a / b;
        end
    endtask

    task automatic read_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            Signal = FN_MFHI;
            #1;
            check_eq({tag, "_hi"}, dataOut, e.hi);
            Signal = FN_MFLO;
            #1;
            check_eq({tag, "_lo"}, dataOut, e.lo);
            Signal = FN_ADD;
            #1;
            check_eq({tag, "_other_zero"}, dataOut, 32'd0);
        end
    endtask

    task automatic run_full(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input bit perturb);
        dataA = a;
        dataB = b;
        tick(FN_DIVU);
        check_eq({tag, "_busy_load"}, {31'd0, busy}, 32'd1);
`ifdef DIVU_ZERO_TRAP_EN
        check_eq({tag, "_divzero"}, {31'd0, divZero}, {31'd0, (b == 32'd0)});
`endif
        for (int i = 1; i < 33; i++) begin
            if (perturb) begin
                dataA = $urandom;
                dataB = $urandom;
            end
            tick(FN_DIVU);
        end
        check_eq({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        tick(FN_OPEN_HILO);
        check_eq({tag, "_busy_commit"}, {31'd0, busy}, 32'd0);
        model_div(a, b);
        sb_q.push_back('{hi: hi_m, lo: lo_m});
        read_check(tag);
    endtask

    initial begin
        reset  = 1'b1;
        dataA  = 32'd0;
        dataB  = 32'd0;
        Signal = FN_MFHI;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mfhi", dataOut, 32'd0);
        Signal = FN_MFLO;
        #1;
        check_eq("rst_mflo", dataOut, 32'd0);
        reset = 1'b0;
        tick(FN_ADD);

        run_full("d100_7", 32'd100, 32'd7, 1'b0);
        run_full("div_zero", 32'h1234_5678, 32'd0, 1'b0);
        run_full("max_by1", 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Abort after 10 DIVU edges: HI/LO must be untouched.
        dataA = 32'd500;
        dataB = 32'd3;
        for (int i = 0; i < 10; i++) tick(FN_DIVU);
        tick(FN_ADD);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        tick(FN_OPEN_HILO);
        check_eq("abort_open_busy", {31'd0, busy}, 32'd0);
        sb_q.push_back('{hi: hi_m, lo: lo_m});
        read_check("abort");

        // Reset asserted around DIVU edge 20 of 40/6.
        dataA = 32'd40;
        dataB = 32'd6;
        for (int i = 0; i < 19; i++) tick(FN_DIVU);
        Signal = FN_DIVU;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        sb_q.push_back('{hi: hi_m, lo: lo_m});
        read_check("midrst");
        reset = 1'b0;
        tick(FN_ADD);
        run_full("d40_6", 32'd40, 32'd6, 1'b0);

        run_full("perturb", 32'd1000, 32'd33, 1'b1);

        for (int k = 0; k < 3; k++) begin
            run_full("rand", $urandom, $urandom_range(1, 32'h0001_FFFF), 1'b0);
        end
        run_full("small_big", 32'd5, 32'hFFFF_FFF0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
